// File: rtl/aes_dsp_fb_skew_if.sv
// aes_dsp_fb_skew_if: data/valid/mode bundle of the feedback row-skew buffer.
// master drives VIN/MODE/DIN and takes DOUT/VOUT/MOUT; slave is the buffer.
// Parity signals DIN_PAR/DOUT_PAR/PERR exist only with AES_FB_SKEW_PARITY_EN.
interface aes_dsp_fb_skew_if #(
   parameter int NB = 4
);
   logic [32*NB-1:0] DIN;
   logic             VIN;
   logic             MODE;
   logic [32*NB-1:0] DOUT;
   logic             VOUT;
   logic             MOUT;
`ifdef AES_FB_SKEW_PARITY_EN
   logic [4*NB-1:0]  DIN_PAR;
   logic [4*NB-1:0]  DOUT_PAR;
   logic             PERR;

   modport master (
      output DIN, VIN, MODE, DIN_PAR,
      input  DOUT, VOUT, MOUT, DOUT_PAR, PERR
   );
   modport slave (
      input  DIN, VIN, MODE, DIN_PAR,
      output DOUT, VOUT, MOUT, DOUT_PAR, PERR
   );
`else
   modport master (
      output DIN, VIN, MODE,
      input  DOUT, VOUT, MOUT
   );
   modport slave (
      input  DIN, VIN, MODE,
      output DOUT, VOUT, MOUT
   );
`endif
endinterface

// File: rtl/aes_dsp_fb_skew.sv
// aes_dsp_fb_skew: (Inv)ShiftRows row-skew buffer for the AES DSP feedback.
// Ports: CLK, RSTN (async low), CE, bus (slave: DIN/VIN/MODE -> DOUT/VOUT/MOUT).
// Params: NB columns (4..8), DLY cycles per offset step, OREG output register.
// Optional macro AES_FB_SKEW_PARITY_EN adds DIN_PAR/DOUT_PAR/PERR checking.
module aes_dsp_fb_skew #(
   parameter int NB   = 4,
   parameter int DLY  = 1,
   parameter int OREG = 0
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE,
   aes_dsp_fb_skew_if.slave bus
);
   localparam int W = 32*NB;

   // Rijndael row offsets; the 256-bit block skips offset 2.
   function automatic int off_f(input int r);
      int o;
      unique case (r)
         0:       o = 0;
         1:       o = 1;
         2:       o = (NB == 8) ? 3 : 2;
         default: o = (NB == 8) ? 4 : 3;
      endcase
      return o;
   endfunction

   if (NB < 4 || NB > 8 || DLY < 1 || OREG < 0 || OREG > 1)
   begin : g_bad_param
      $error("aes_dsp_fb_skew: illegal NB=%0d DLY=%0d OREG=%0d",
             NB, DLY, OREG);
   end

   // Rows 1..3: column rotation happens before the delay line so each
   // byte uses the mode that arrived with it.
   for (genvar r = 1; r < 4; r++) begin : g_row
      localparam int OF = off_f(r);
      localparam int D  = DLY*OF;

      logic [8*NB-1:0] wr;
      logic [8*NB-1:0] dl [D];
      logic [D-1:0]    vl;
      logic [D-1:0]    ml;
      logic [8*NB-1:0] ob;
      logic            ov;
      logic            om;
`ifdef AES_FB_SKEW_PARITY_EN
      logic [NB-1:0]   pw;
      logic [NB-1:0]   pl [D];
      logic [NB-1:0]   op;
`endif

      for (genvar j = 0; j < NB; j++) begin : g_col
         localparam int SP = (j + OF) % NB;
         localparam int SM = (j - OF + NB) % NB;
         assign wr[8*j +: 8] = bus.MODE ?
            bus.DIN[W-1-32*SM-8*r -: 8] :
            bus.DIN[W-1-32*SP-8*r -: 8];
`ifdef AES_FB_SKEW_PARITY_EN
         assign pw[j] = bus.MODE ?
            bus.DIN_PAR[4*NB-1-4*SM-r] :
            bus.DIN_PAR[4*NB-1-4*SP-r];
`endif
      end

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            for (int i = 0; i < D; i++) begin
               dl[i] <= '0;
`ifdef AES_FB_SKEW_PARITY_EN
               pl[i] <= '0;
`endif
            end
            vl <= '0;
            ml <= '0;
         end else if (CE) begin
            dl[0] <= wr;
            vl[0] <= bus.VIN;
            ml[0] <= bus.MODE;
`ifdef AES_FB_SKEW_PARITY_EN
            pl[0] <= pw;
`endif
            for (int i = 1; i < D; i++) begin
               dl[i] <= dl[i-1];
               vl[i] <= vl[i-1];
               ml[i] <= ml[i-1];
`ifdef AES_FB_SKEW_PARITY_EN
               pl[i] <= pl[i-1];
`endif
            end
         end
      end

      assign ob = dl[D-1];
      assign ov = vl[D-1];
      assign om = ml[D-1];
`ifdef AES_FB_SKEW_PARITY_EN
      assign op = pl[D-1];
`endif
   end

   logic [3:0]   rv;
   logic [3:0]   rm;
   logic [W-1:0] dc;
   logic         vc;

   assign rv = {g_row[3].ov, g_row[2].ov,
                g_row[1].ov, bus.VIN};
   assign rm = {g_row[3].om, g_row[2].om,
                g_row[1].om, bus.MODE};

   // A word is valid only when every row is valid and no mode change
   // falls inside the skew window.
   assign vc = CE & (&rv) & ((&rm) | ~(|rm));

   always_comb begin
      dc = '0;
      for (int j = 0; j < NB; j++) begin
         dc[W-1-32*j  -: 8] = bus.DIN[W-1-32*j -: 8];
         dc[W-9-32*j  -: 8] = g_row[1].ob[8*j +: 8];
         dc[W-17-32*j -: 8] = g_row[2].ob[8*j +: 8];
         dc[W-25-32*j -: 8] = g_row[3].ob[8*j +: 8];
      end
   end

`ifdef AES_FB_SKEW_PARITY_EN
   logic [4*NB-1:0] pc;

   always_comb begin
      pc = '0;
      for (int j = 0; j < NB; j++) begin
         pc[4*NB-1-4*j] = bus.DIN_PAR[4*NB-1-4*j];
         pc[4*NB-2-4*j] = g_row[1].op[j];
         pc[4*NB-3-4*j] = g_row[2].op[j];
         pc[4*NB-4-4*j] = g_row[3].op[j];
      end
   end
`endif

   logic [W-1:0] dout_o;
   logic         vout_o;
   logic         mout_o;
`ifdef AES_FB_SKEW_PARITY_EN
   logic [4*NB-1:0] dpar_o;
`endif

   if (OREG != 0) begin : g_oreg
      logic [W-1:0] dout_q;
      logic         vout_q;
      logic         mout_q;
`ifdef AES_FB_SKEW_PARITY_EN
      logic [4*NB-1:0] dpar_q;
`endif

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            dout_q <= '0;
            vout_q <= 1'b0;
            mout_q <= 1'b0;
`ifdef AES_FB_SKEW_PARITY_EN
            dpar_q <= '0;
`endif
         end else if (CE) begin
            dout_q <= dc;
            vout_q <= vc;
            mout_q <= bus.MODE;
`ifdef AES_FB_SKEW_PARITY_EN
            dpar_q <= pc;
`endif
         end
      end

      assign dout_o = dout_q;
      assign vout_o = vout_q;
      assign mout_o = mout_q;
`ifdef AES_FB_SKEW_PARITY_EN
      assign dpar_o = dpar_q;
`endif
   end else begin : g_comb
      assign dout_o = dc;
      assign vout_o = vc;
      assign mout_o = bus.MODE;
`ifdef AES_FB_SKEW_PARITY_EN
      assign dpar_o = pc;
`endif
   end

   assign bus.DOUT = dout_o;
   assign bus.VOUT = vout_o;
   assign bus.MOUT = mout_o;

`ifdef AES_FB_SKEW_PARITY_EN
   logic perr_q;
   logic bad;
   logic err_now;

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < 4*NB; i++) begin
         if ((^dout_o[8*i +: 8]) != dpar_o[i]) bad = 1'b1;
      end
   end

   // Error is visible in the same cycle as the bad word, then sticks.
   assign err_now = vout_o & bad;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) perr_q <= 1'b0;
      else       perr_q <= perr_q | err_now;
   end

   assign bus.DOUT_PAR = dpar_o;
   assign bus.PERR     = perr_q | err_now;
`endif
endmodule

// File: tb/tb_aes_dsp_fb_skew.sv
// tb_aes_dsp_fb_skew: drives NB=4/DLY=1/OREG=0 and NB=8/DLY=2/OREG=1 buffers
// with shared stimulus; expected words come from an input-history model.
`timescale 1ns/1ps
module tb_aes_dsp_fb_skew;
   logic         CLK  = 1'b0;
   logic         RSTN = 1'b0;
   logic         CE   = 1'b0;
   logic         vin  = 1'b0;
   logic         mode = 1'b0;
   logic [255:0] din  = '0;

   int vectors     = 0;
   int miscompares = 0;

   logic [255:0] hd [4096];
   bit           hv [4096];
   bit           hm [4096];
   int           n = 0;

   logic [127:0] obs_d0;
   logic [255:0] obs_d1;
   logic         obs_v0, obs_v1, obs_m0, obs_m1;

   always #5 CLK = ~CLK;

   aes_dsp_fb_skew_if #(.NB(4)) b0 ();
   aes_dsp_fb_skew_if #(.NB(8)) b1 ();

   assign b0.DIN  = din[127:0];
   assign b0.VIN  = vin;
   assign b0.MODE = mode;
   assign b1.DIN  = din;
   assign b1.VIN  = vin;
   assign b1.MODE = mode;

`ifdef AES_FB_SKEW_PARITY_EN
   function automatic logic [31:0] par_of(input logic [255:0] d,
                                          input int nb);
      logic [31:0] p;
      p = '0;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            p[4*nb-1-4*c-r] = ^d[32*nb-1-32*c-8*r -: 8];
      return p;
   endfunction
   logic [31:0] p4, p8;
   assign p4 = par_of(din, 4);
   assign p8 = par_of(din, 8);
   assign b0.DIN_PAR = p4[15:0];
   assign b1.DIN_PAR = p8;
`endif

   aes_dsp_fb_skew #(.NB(4), .DLY(1), .OREG(0)) u0 (
      .CLK(CLK), .RSTN(RSTN), .CE(CE), .bus(b0.slave));
   aes_dsp_fb_skew #(.NB(8), .DLY(2), .OREG(1)) u1 (
      .CLK(CLK), .RSTN(RSTN), .CE(CE), .bus(b1.slave));

   function automatic int offs(input int nb, input int r);
      if (r == 0) return 0;
      if (r == 1) return 1;
      if (r == 2) return (nb == 8) ? 3 : 2;
      return (nb == 8) ? 4 : 3;
   endfunction

   function automatic logic [7:0] gb(input logic [255:0] d,
                                     input int nb, input int c,
                                     input int r);
      return d[32*nb-1-32*c-8*r -: 8];
   endfunction

   // Expected outputs from the list of accepted (CE=1) input words.
   function automatic void model(input int nb, input int dly,
                                 input bit oreg,
                                 output logic [255:0] od,
                                 output bit ov, output bit om);
      int idx, k, o, s;
      logic [255:0] cd;
      bit cv, cm, cce, allv, same, v, m;
      od = '0; ov = 0; om = 0;
      if (oreg) begin
         if (n == 0) return;
         idx = n - 1; cd = hd[idx];
         cv = hv[idx]; cm = hm[idx]; cce = 1;
      end else begin
         idx = n; cd = din; cv = vin; cm = mode; cce = CE;
      end
      allv = cv; same = 1;
      for (int j = 0; j < nb; j++)
         od[32*nb-1-32*j -: 8] = gb(cd, nb, j, 0);
      for (int r = 1; r < 4; r++) begin
         o = offs(nb, r);
         k = idx - dly*o;
         v = (k >= 0) ? hv[k] : 1'b0;
         m = (k >= 0) ? hm[k] : 1'b0;
         allv = allv & v;
         if (m != cm) same = 0;
         if (k >= 0)
            for (int j = 0; j < nb; j++) begin
               s = m ? (j - o + nb) % nb : (j + o) % nb;
               od[32*nb-1-32*j-8*r -: 8] = gb(hd[k], nb, s, r);
            end
      end
      ov = cce & allv & same;
      om = cm;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_now(input bit full);
      logic [255:0] od;
      bit ov, om;
      obs_d0 = b0.DOUT; obs_v0 = b0.VOUT; obs_m0 = b0.MOUT;
      obs_d1 = b1.DOUT; obs_v1 = b1.VOUT; obs_m1 = b1.MOUT;
      model(4, 1, 1'b0, od, ov, om);
      chk("u0.vout", obs_v0, ov);
      chk("u0.mout", obs_m0, om);
      if (ov || full) chk("u0.dout", obs_d0, od);
      model(8, 2, 1'b1, od, ov, om);
      chk("u1.vout", obs_v1, ov);
      chk("u1.mout", obs_m1, om);
      if (ov || full) chk("u1.dout", obs_d1, od);
`ifdef AES_FB_SKEW_PARITY_EN
      chk("u0.perr", b0.PERR, 0);
      chk("u1.perr", b1.PERR, 0);
`endif
   endtask

   // Called at posedge+1: apply, check mid-cycle, clock, record.
   task automatic cyc(input bit ce, input bit v, input bit m,
                      input logic [255:0] d, input bit full);
      CE = ce; vin = v; mode = m; din = d;
      #4;
      check_now(full);
      @(posedge CLK);
      if (RSTN && CE && n < 4096) begin
         hd[n] = din; hv[n] = vin; hm[n] = mode; n++;
      end
      #1;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [255:0] pat4();
      logic [255:0] d;
      d = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            d[127-32*c-8*r -: 8] = 8'(16*c + r);
      return d;
   endfunction

   logic [255:0] sd [32];

   initial begin
      int cnt0, cnt1, f0, f1;
      bit m;
      @(posedge CLK); #1;

      // reset state, inputs active
      for (int t = 0; t < 2; t++)
         cyc(1, 1, t[0], rnd256(), 1);
      RSTN = 1'b1;

      // single VIN pulse: never a complete word
      cnt0 = 0; cnt1 = 0;
      for (int t = 0; t < 14; t++) begin
         cyc(1, t == 0, 0, rnd256(), 0);
         cnt0 += int'(obs_v0); cnt1 += int'(obs_v1);
      end
      chk("pulse.u0.nvout", cnt0, 0);
      chk("pulse.u1.nvout", cnt1, 0);

      // continuous ShiftRows stream of the reference pattern
      f0 = -1; f1 = -1;
      for (int t = 0; t < 14; t++) begin
         cyc(1, 1, 0, pat4(), 0);
         if (obs_v0 && f0 < 0) f0 = t;
         if (obs_v1 && f1 < 0) f1 = t;
         if (t >= 3) begin
            chk("enc.col0", obs_d0[127:96], 32'h00112233);
            chk("enc.col3", obs_d0[31:0], 32'h30011223);
         end
      end
      chk("enc.u0.first", f0, 3);
      chk("enc.u1.first", f1, 9);

      // switch to InvShiftRows mid-stream
      cnt0 = 0; cnt1 = 0;
      for (int t = 0; t < 12; t++) begin
         cyc(1, 1, 1, pat4(), 0);
         cnt0 += int'(!obs_v0); cnt1 += int'(!obs_v1);
      end
      chk("dec.u0.gap", cnt0, 3);
      chk("dec.u1.gap", cnt1, 8);
      chk("dec.col0", obs_d0[127:96], 32'h00312213);
      chk("dec.u0.mout", obs_m0, 1);
      chk("dec.u1.mout", obs_m1, 1);

      // CE toggling
      for (int t = 0; t < 20; t++)
         cyc(!t[0], 1, 1, rnd256(), 0);

      // random traffic
      m = 0;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 19) == 0) m = !m;
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
             m, rnd256(), 0);
      end

      // async reset in the middle of a stream
      CE = 1; vin = 1; mode = 0; din = rnd256();
      #2;
      RSTN = 1'b0; n = 0;
      #1;
      check_now(1);
      @(posedge CLK); #1;
      cyc(1, 1, 0, rnd256(), 1);
      RSTN = 1'b1;
      f0 = -1; f1 = -1;
      for (int t = 0; t < 16; t++) begin
         sd[t] = rnd256();
         cyc(1, 1, 0, sd[t], 0);
         if (obs_v0 && f0 < 0) f0 = t;
         if (obs_v1 && f1 < 0) f1 = t;
         if (t >= 10)
            chk("u1.r3c0.age", obs_d1[231:224], gb(sd[t-9], 8, 4, 3));
      end
      chk("rst.u0.first", f0, 3);
      chk("rst.u1.first", f1, 9);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
